// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front end:
//   - NB_OP      : opcode width (low NB_OP switches carry the opcode)
//   - OP_*       : the eight opcodes the ALU implements
//   - ld_mask_t  : one "has been loaded" bit per input field
//   - is_valid_op: 1 when an opcode is one the ALU implements
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int NB_OP = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    // Field order matches the {op,b,a} mask layout.
    typedef struct packed {
        logic op;
        logic b;
        logic a;
    } ld_mask_t;

    function automatic logic is_valid_op(input logic [NB_OP-1:0] i_op);
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
            default:                        is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Turns one raw, asynchronous push-button into a single-cycle press strobe.
// A 2-flop synchronizer brings the button into the i_clk domain; a press is
// reported once per button hold, and a new press needs the synchronized level
// to drop low for at least one cycle.
//
// Optional feature (macro ALU_LOADER_DEBOUNCE_EN):
//   defined   - a saturating counter runs while the synchronized level is
//               high; the press fires on the DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES
//               step, so shorter highs are ignored.
//   undefined - press = rising edge of the synchronized level.
//
// Ports:
//   i_clk    in  1  system clock
//   i_reset  in  1  synchronous, active-high reset
//   i_btn    in  1  raw button level
//   o_press  out 1  one-cycle press strobe (combinational from flops)
// ---------------------------------------------------------------------------
module btn_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync_p0;
    logic r_sync_p1;

    // Stage p0/p1: two-flop synchronizer for the asynchronous button.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_btn;
            r_sync_p1 <= r_sync_p0;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt_p2;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] i_cnt);
        sat_inc = (i_cnt == CNT_MAX) ? i_cnt : i_cnt + CW'(1);
    endfunction

    // Stage p2: stable-high counter; saturation keeps a held button from
    // ever reaching the arming value again.
    always_ff @(posedge i_clk) begin
        if (i_reset || !r_sync_p1) begin
            r_cnt_p2 <= '0;
        end else begin
            r_cnt_p2 <= sat_inc(r_cnt_p2);
        end
    end

    assign o_press = r_sync_p1 && (r_cnt_p2 == CNT_ARM);
`else
    // Without debounce the count is unused; a non-positive value is still
    // treated as a broken configuration so both builds fail the same way.
    localparam logic DEB_OK = (DEBOUNCE_CYCLES >= 1);

    logic r_prev_p2;

    // Stage p2: previous synchronized level for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_p2 <= 1'b0;
        end else begin
            r_prev_p2 <= r_sync_p1;
        end
    end

    assign o_press = r_sync_p1 & ~r_prev_p2 & DEB_OK;
`endif

endmodule

// File: rtl/alu_input_loader.sv
// ---------------------------------------------------------------------------
// alu_input_loader
// Board front end for the ALU. One shared switch bank is latched into
// operand A, operand B or the opcode, one field per button press, and held
// as stable registered ALU inputs. Unsupported opcodes are rejected and
// flagged; o_ready tells the ALU side that a full operand set is present.
//
// Optional feature: ALU_LOADER_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stable-high
// requirement to each button path (see btn_edge).
//
// Ports:
//   i_clk        in  1          system clock
//   i_reset      in  1          synchronous, active-high reset
//   i_sw         in  NB_INPUTS  switch bank shared by all fields
//   i_btn_a      in  1          raw button: load operand A
//   i_btn_b      in  1          raw button: load operand B
//   i_btn_op     in  1          raw button: load opcode (low NB_OP switches)
//   o_dato_a     out NB_INPUTS  registered operand A
//   o_dato_b     out NB_INPUTS  registered operand B
//   o_operation  out NB_OP      registered opcode (ADD after reset)
//   o_ready      out 1          A, B and a valid op all loaded since reset
//   o_update     out 1          one-cycle pulse after a load with set complete
//   o_op_err     out 1          sticky unsupported-opcode flag
// ---------------------------------------------------------------------------
import alu_pkg::*;

module alu_input_loader #(
    parameter int NB_INPUTS       = 8,
    parameter int NB_OP           = alu_pkg::NB_OP,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_INPUTS-1:0] i_sw,
    input  logic                 i_btn_a,
    input  logic                 i_btn_b,
    input  logic                 i_btn_op,
    output logic [NB_INPUTS-1:0] o_dato_a,
    output logic [NB_INPUTS-1:0] o_dato_b,
    output logic [NB_OP-1:0]     o_operation,
    output logic                 o_ready,
    output logic                 o_update,
    output logic                 o_op_err
);

    localparam logic [NB_OP-1:0] OP_RESET = OP_ADD;

    logic             w_press_a;
    logic             w_press_b;
    logic             w_press_op;
    logic [NB_OP-1:0] w_op_sw;
    logic             w_op_ok;
    logic             w_op_rej;
    ld_mask_t         w_ld;
    ld_mask_t         w_mask_nxt;

    logic [NB_INPUTS-1:0] r_dato_a;
    logic [NB_INPUTS-1:0] r_dato_b;
    logic [NB_OP-1:0]     r_operation;
    ld_mask_t             r_mask;
    logic                 r_ready;
    logic                 r_update;
    logic                 r_op_err;

    // Stage p0..p2: per-button synchronize and press detect.
    btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_a),
        .o_press (w_press_a)
    );

    btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_b),
        .o_press (w_press_b)
    );

    btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_op),
        .o_press (w_press_op)
    );

    assign w_op_sw  = i_sw[NB_OP-1:0];
    assign w_op_ok  = is_valid_op(w_op_sw);
    assign w_op_rej = w_press_op & ~w_op_ok;

    // Accepted loads; a rejected opcode leaves both o_operation and its mask
    // bit alone, so it can never complete the operand set.
    always_comb begin
        w_ld       = '0;
        w_ld.a     = w_press_a;
        w_ld.b     = w_press_b;
        w_ld.op    = w_press_op & w_op_ok;
        w_mask_nxt = ld_mask_t'(r_mask | w_ld);
    end

    // Stage p3: field registers and status. Ready and update look at the
    // post-load mask so they rise at the completing load edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dato_a    <= '0;
            r_dato_b    <= '0;
            r_operation <= OP_RESET;
            r_mask      <= '0;
            r_ready     <= 1'b0;
            r_update    <= 1'b0;
            r_op_err    <= 1'b0;
        end else begin
            if (w_ld.a) begin
                r_dato_a <= i_sw;
            end
            if (w_ld.b) begin
                r_dato_b <= i_sw;
            end
            if (w_ld.op) begin
                r_operation <= w_op_sw;
            end

            r_mask   <= w_mask_nxt;
            r_ready  <= &w_mask_nxt;
            // Simultaneous loads collapse into a single pulse.
            r_update <= (|w_ld) & (&w_mask_nxt);

            if (w_ld.op) begin
                r_op_err <= 1'b0;
            end else if (w_op_rej) begin
                r_op_err <= 1'b1;
            end
        end
    end

    assign o_dato_a    = r_dato_a;
    assign o_dato_b    = r_dato_b;
    assign o_operation = r_operation;
    assign o_ready     = r_ready;
    assign o_update    = r_update;
    assign o_op_err    = r_op_err;

endmodule

// File: tb/tb_alu_input_loader.sv
module tb_alu_input_loader;

    localparam int DEB = 4;
`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int N_EFF = DEB;
`else
    localparam int N_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_sw;
    logic       i_btn_a;
    logic       i_btn_b;
    logic       i_btn_op;
    logic [7:0] o_dato_a;
    logic [7:0] o_dato_b;
    logic [5:0] o_operation;
    logic       o_ready;
    logic       o_update;
    logic       o_op_err;

    always #5 clk = ~clk;

    alu_input_loader #(
        .NB_INPUTS       (8),
        .NB_OP           (6),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_sw        (i_sw),
        .i_btn_a     (i_btn_a),
        .i_btn_b     (i_btn_b),
        .i_btn_op    (i_btn_op),
        .o_dato_a    (o_dato_a),
        .o_dato_b    (o_dato_b),
        .o_operation (o_operation),
        .o_ready     (o_ready),
        .o_update    (o_update),
        .o_op_err    (o_op_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_upd = 0;

    // Reference model state (transaction level).
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    logic [5:0] m_op   = 6'b100000;
    logic       m_err  = 1'b0;
    logic       m_rdy  = 1'b0;
    logic       m_upd  = 1'b0;
    logic [2:0] m_seen = '0;

    // Per button: sampled levels at past edges, index 0 = most recent.
    bit hist [3][N_EFF+2];

    logic [5:0] ops_tbl [0:7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    function automatic bit op_supported(input logic [5:0] v);
        bit hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ops_tbl[i] == v) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, apply the model at the edge, compare at the negedge.
    // A load happens at an edge when the button has been sampled high on the
    // N_EFF edges ending two edges earlier, and low just before that window.
    task automatic cycle(input logic [2:0] btn, input logic [7:0] sw, input logic rst);
        logic [2:0] ld;
        logic [2:0] acc;
        bit         ok;
        i_btn_a  = btn[0];
        i_btn_b  = btn[1];
        i_btn_op = btn[2];
        i_sw     = sw;
        i_reset  = rst;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ld[i] = !rst && !hist[i][N_EFF+1];
            for (int j = 1; j <= N_EFF; j++) ld[i] = ld[i] && hist[i][j];
            for (int j = N_EFF + 1; j >= 1; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = btn[i] && !rst;
            if (rst) begin
                for (int j = 0; j <= N_EFF + 1; j++) hist[i][j] = 1'b0;
            end
        end
        if (rst) begin
            m_a = '0; m_b = '0; m_op = 6'b100000;
            m_err = 1'b0; m_seen = '0; m_rdy = 1'b0; m_upd = 1'b0;
        end else begin
            ok  = op_supported(sw[5:0]);
            acc = {ld[2] & ok, ld[1], ld[0]};
            if (acc[0]) m_a = sw;
            if (acc[1]) m_b = sw;
            if (acc[2]) m_op = sw[5:0];
            if (ld[2]) m_err = !ok;
            m_seen = m_seen | acc;
            m_rdy  = &m_seen;
            m_upd  = (|acc) && m_rdy;
        end
        @(negedge clk);
        if (o_update === 1'b1) n_upd++;
        chk("dato_a",    32'(o_dato_a),    32'(m_a));
        chk("dato_b",    32'(o_dato_b),    32'(m_b));
        chk("operation", 32'(o_operation), 32'(m_op));
        chk("ready",     32'(o_ready),     32'(m_rdy));
        chk("update",    32'(o_update),    32'(m_upd));
        chk("op_err",    32'(o_op_err),    32'(m_err));
    endtask

    task automatic press(input logic [2:0] btn, input logic [7:0] sw, input int hold, input int tail);
        for (int c = 0; c < hold; c++) cycle(btn, sw, 1'b0);
        for (int c = 0; c < tail; c++) cycle(3'b000, sw, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         u0;
        logic [7:0] a0;
        logic [2:0] lv;
        logic [7:0] sw;
        logic       rst;
        i_reset = 1'b1; i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0; i_sw = '0;

        // Reset, then idle.
        for (int c = 0; c < 3; c++) cycle(3'b000, 8'h00, 1'b1);
        for (int c = 0; c < 20; c++) cycle(3'b000, 8'h00, 1'b0);
        chk("idle_op",    32'(o_operation), 32'h20);
        chk("idle_a",     32'(o_dato_a),    32'h0);
        chk("idle_ready", 32'(o_ready),     32'h0);

        // Load A, B, then SUB.
        press(3'b001, 8'h05, 6, N_EFF + 3);
        chk("load_a", 32'(o_dato_a), 32'h05);
        press(3'b010, 8'h03, 6, N_EFF + 3);
        chk("load_b",      32'(o_dato_b), 32'h03);
        chk("ready_early", 32'(o_ready),  32'h0);
        u0 = n_upd;
        press(3'b100, 8'h22, 6, N_EFF + 3);
        chk("load_op",     32'(o_operation), 32'h22);
        chk("ready_set",   32'(o_ready),     32'h1);
        chk("upd_pulses",  32'(n_upd - u0),  32'h1);

        // Unsupported opcode, then AND.
        u0 = n_upd;
        press(3'b100, 8'h3F, 6, N_EFF + 3);
        chk("bad_op_err",  32'(o_op_err),    32'h1);
        chk("bad_op_keep", 32'(o_operation), 32'h22);
        chk("bad_op_upd",  32'(n_upd - u0),  32'h0);
        u0 = n_upd;
        press(3'b100, 8'h24, 6, N_EFF + 3);
        chk("and_op",     32'(o_operation), 32'h24);
        chk("and_err",    32'(o_op_err),    32'h0);
        chk("and_upd",    32'(n_upd - u0),  32'h1);

        // Long hold: switches change after the load, single load only.
        u0 = n_upd;
        for (int c = 0; c < 50; c++) cycle(3'b001, (c < 10) ? 8'h11 : 8'h22, 1'b0);
        for (int c = 0; c < N_EFF + 3; c++) cycle(3'b000, 8'h22, 1'b0);
        chk("hold_a",   32'(o_dato_a),   32'h11);
        chk("hold_upd", 32'(n_upd - u0), 32'h1);

`ifdef ALU_LOADER_DEBOUNCE_EN
        // Short glitch ignored, longer pulse accepted.
        a0 = o_dato_a;
        press(3'b001, 8'h77, DEB - 1, DEB + 4);
        chk("glitch_a", 32'(o_dato_a), 32'(a0));
        press(3'b001, 8'h66, DEB + 2, DEB + 4);
        chk("deb_a", 32'(o_dato_a), 32'h66);
`endif

        // Reset while a button is held: it is seen again as a new press.
        cycle(3'b001, 8'h5A, 1'b0);
        cycle(3'b001, 8'h5A, 1'b1);
        cycle(3'b001, 8'h5A, 1'b1);
        press(3'b001, 8'h5A, 6, N_EFF + 3);
        chk("rst_held_a",     32'(o_dato_a), 32'h5A);
        chk("rst_held_ready", 32'(o_ready),  32'h0);

        // Randomized traffic with occasional resets.
        lv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) lv[i] = ~lv[i];
            end
            if ($urandom_range(0, 1) == 1) sw = {2'($urandom), ops_tbl[$urandom_range(0, 7)]};
            else                           sw = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            cycle(lv, sw, rst);
        end
        for (int c = 0; c < N_EFF + 3; c++) cycle(3'b000, 8'h00, 1'b0);

        // Simultaneous A and B, then reset.
        press(3'b011, 8'hAA, 6, N_EFF + 3);
        chk("simul_a", 32'(o_dato_a), 32'hAA);
        chk("simul_b", 32'(o_dato_b), 32'hAA);
        cycle(3'b000, 8'hAA, 1'b1);
        chk("post_rst_ready", 32'(o_ready),     32'h0);
        chk("post_rst_op",    32'(o_operation), 32'h20);
        chk("post_rst_a",     32'(o_dato_a),    32'h0);
        chk("post_rst_b",     32'(o_dato_b),    32'h0);
        for (int c = 0; c < 5; c++) cycle(3'b000, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
